// File: rtl/comparator_pkg.sv
// Shared types and relation encodings for the serial magnitude comparator
// and any other block that consumes a three-way relation result.
package comparator_pkg;

  // Comparator control states
  typedef enum logic [1:0] {
    CMP_IDLE  = 2'd0,
    CMP_SHIFT = 2'd1,
    CMP_DONE  = 2'd2
  } cmp_state_t;

  // Relation encoding, bit order {EQ, GT, LT}; exactly one bit set once a
  // compare has finished, all zero while a compare is pending.
  localparam int         REL_W    = 3;
  localparam logic [2:0] REL_NONE = 3'b000;
  localparam logic [2:0] REL_EQ   = 3'b100;
  localparam logic [2:0] REL_GT   = 3'b010;
  localparam logic [2:0] REL_LT   = 3'b001;

endpackage : comparator_pkg

// File: rtl/comparator_rel_serial.sv
// Bit-serial, MSB-first unsigned magnitude comparator.
// Operands are captured on an accepted start, then one bit pair is compared
// per cycle; the first differing bit decides the result immediately.
// busy/done/EQ/GT/LT all come straight from flops.
module comparator_rel_serial
  import comparator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             EQ,
  output logic             GT,
  output logic             LT
);

  // Counter just wide enough to hold WIDTH-1
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  generate
    if (WIDTH < 2) begin : g_width_check
      $error("comparator_rel_serial: WIDTH must be >= 2");
    end
  endgenerate

  cmp_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REL_W-1:0] rel_q, rel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             a_msb_s;
  logic             b_msb_s;
  logic             bits_differ_s;
  logic             last_bit_s;

  assign a_msb_s       = a_sh_q[WIDTH-1];
  assign b_msb_s       = b_sh_q[WIDTH-1];
  assign bits_differ_s = (a_msb_s != b_msb_s);
  assign last_bit_s    = (cnt_q == {CNT_W{1'b0}});

  // State, datapath and output registers; async reset aborts any compare
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CMP_IDLE;
      a_sh_q  <= {WIDTH{1'b0}};
      b_sh_q  <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      rel_q   <= REL_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: leave SHIFT on the first differing bit or after the LSB
  always_comb begin
    state_d = state_q;
    case (state_q)
      CMP_IDLE: begin
        if (start) begin
          state_d = CMP_SHIFT;
        end else begin
          state_d = CMP_IDLE;
        end
      end
      CMP_SHIFT: begin
        if (bits_differ_s || last_bit_s) begin
          state_d = CMP_DONE;
        end else begin
          state_d = CMP_SHIFT;
        end
      end
      CMP_DONE: begin
        state_d = CMP_IDLE;
      end
      default: begin
        state_d = CMP_IDLE;
      end
    endcase
  end

  // Datapath: capture operands, shift MSB-first, and record the relation
  always_comb begin
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    cnt_d  = cnt_q;
    rel_d  = rel_q;
    case (state_q)
      CMP_IDLE: begin
        if (start) begin
          a_sh_d = a;
          b_sh_d = b;
          cnt_d  = CNT_W'(WIDTH - 1);
          rel_d  = REL_NONE;
        end else begin
          rel_d  = rel_q;
        end
      end
      CMP_SHIFT: begin
        if (bits_differ_s) begin
          // The operand holding the 1 is the larger one
          rel_d = a_msb_s ? REL_GT : REL_LT;
        end else if (last_bit_s) begin
          rel_d = REL_EQ;
        end else begin
          a_sh_d = {a_sh_q[WIDTH-2:0], 1'b0};
          b_sh_d = {b_sh_q[WIDTH-2:0], 1'b0};
          cnt_d  = cnt_q - CNT_W'(1);
        end
      end
      CMP_DONE: begin
        rel_d = rel_q;
      end
      default: begin
        rel_d = REL_NONE;
      end
    endcase
  end

  // Output decode from the next state so busy/done line up with the state flop
  always_comb begin
    busy_d = (state_d != CMP_IDLE);
    done_d = (state_d == CMP_DONE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign EQ   = rel_q[2];
  assign GT   = rel_q[1];
  assign LT   = rel_q[0];

endmodule : comparator_rel_serial

// File: tb/tb_comparator_rel_serial.sv
// Self-checking bench for comparator_rel_serial (WIDTH=8): directed corner
// cases plus randomized operands against an arithmetic reference model.
module tb_comparator_rel_serial;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         EQ;
  logic         GT;
  logic         LT;

  int n_tests = 0;
  int n_fail  = 0;

  comparator_rel_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .EQ    (EQ),
    .GT    (GT),
    .LT    (LT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports mismatches
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference relation as {EQ,GT,LT} from plain unsigned comparison
  function automatic logic [2:0] ref_rel(input logic [W-1:0] x, input logic [W-1:0] y);
    if (x == y)     return 3'b100;
    else if (x > y) return 3'b010;
    else            return 3'b001;
  endfunction

  // Reference latency: W minus the position of the highest differing bit
  function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
    int diff;
    diff = int'(x ^ y);
    if (diff == 0) return W;
    return W - ($clog2(diff + 1) - 1);
  endfunction

  // Assumes we sit at the negedge after the accept edge; counts SHIFT cycles to done
  task automatic wait_done(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                           input bit toggle, input bit hold);
    int  n;
    bit  found;
    n     = 0;
    found = 1'b0;
    while (!found && n < W + 4) begin
      @(negedge clk);
      n++;
      if (toggle) begin
        a = W'($urandom);
        b = W'($urandom);
      end
      if (done) begin
        found = 1'b1;
      end else begin
        check_val("busy_in_shift", 32'(busy), 32'd1);
        check_val("flags_clear_pending", 32'({EQ, GT, LT}), 32'd0);
      end
    end
    check_val("done_seen", 32'(found), 32'd1);
    check_val("latency", 32'(n), 32'(ref_lat(ta, tb2)));
    check_val("flags_at_done", 32'({EQ, GT, LT}), 32'(ref_rel(ta, tb2)));
    check_val("busy_at_done", 32'(busy), 32'd1);
    if (hold) begin
      check_val("start_held", 32'(start), 32'd1);
    end else begin
      check_val("start_low", 32'(start), 32'd0);
    end
  endtask

  // One full request; optional operand toggling and start held high throughout
  task automatic run_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                         input bit toggle, input bit hold);
    @(negedge clk);
    a     = ta;
    b     = tb2;
    start = 1'b1;
    @(posedge clk);               // E0: start sampled in IDLE
    @(negedge clk);
    if (!hold) start = 1'b0;
    check_val("busy_after_accept", 32'(busy), 32'd1);
    check_val("flags_cleared", 32'({EQ, GT, LT}), 32'd0);
    wait_done(ta, tb2, toggle, hold);
    @(negedge clk);
    check_val("idle_busy", 32'(busy), 32'd0);
    check_val("idle_done", 32'(done), 32'd0);
    check_val("flags_held", 32'({EQ, GT, LT}), 32'(ref_rel(ta, tb2)));
    if (hold) begin
      // Start still high in this first IDLE cycle: accepted on the coming edge
      a = ta;
      b = tb2;
      @(negedge clk);
      start = 1'b0;
      check_val("reaccept_busy", 32'(busy), 32'd1);
      check_val("reaccept_flags", 32'({EQ, GT, LT}), 32'd0);
      wait_done(ta, tb2, 1'b0, 1'b0);
      @(negedge clk);
      check_val("reaccept_idle", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    bit saw_done;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check_val("reset_outputs", 32'({busy, done, EQ, GT, LT}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_reset_idle", 32'({busy, done, EQ, GT, LT}), 32'd0);

    // Directed cases
    run_cmp(8'd50,  8'd50,  1'b0, 1'b0);   // equal, full latency
    run_cmp(8'd100, 8'd50,  1'b0, 1'b0);   // bit6 differs
    run_cmp(8'd200, 8'd199, 1'b1, 1'b0);   // bit3, operands toggled while busy
    run_cmp(8'd0,   8'd10,  1'b0, 1'b1);   // LT, start held high
    run_cmp(8'd128, 8'd0,   1'b0, 1'b0);   // minimum latency
    run_cmp(8'd0,   8'd0,   1'b0, 1'b0);
    run_cmp(8'd255, 8'd254, 1'b0, 1'b0);   // LSB-only difference
    run_cmp(8'd1,   8'd0,   1'b0, 1'b0);

    // Reset in the middle of a compare
    @(negedge clk);
    a     = 8'd255;
    b     = 8'd255;
    start = 1'b1;
    @(posedge clk);                        // E0
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);             // E3
    #1;
    rst_n = 1'b0;
    #1;
    check_val("abort_outputs", 32'({busy, done, EQ, GT, LT}), 32'd0);
    saw_done = 1'b0;
    repeat (W + 2) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check_val("abort_no_done", 32'(saw_done), 32'd0);
    rst_n = 1'b1;
    run_cmp(8'd255, 8'd255, 1'b0, 1'b0);

    // Randomized operands; bias some pairs to share high bits
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 4 == 1) rb = ra;
      if (i % 4 == 2) rb = ra ^ W'(1 << $urandom_range(0, W - 1));
      run_cmp(ra, rb, (i % 3 == 0), (i % 7 == 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_comparator_rel_serial
